// File: rtl/issue_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
// Shared definitions for the issue scheduler: op/unit type codes and the
// age helper used to rotate the eligible vector so the commit head is age 0.
// -----------------------------------------------------------------------------
package issue_pkg;

  localparam int OP_TYPE_W = 2;

  typedef logic [OP_TYPE_W-1:0] op_type_t;

  localparam op_type_t TYPE_ALU   = 2'd0;
  localparam op_type_t TYPE_SHIFT = 2'd1;
  localparam op_type_t TYPE_MUL   = 2'd2;
  localparam op_type_t TYPE_BR    = 2'd3;

  // Age of commit entry idx relative to head in a ring of n entries
  // (n a power of 2, so the mask is the modulo).
  function automatic int unsigned age_of(input int unsigned idx,
                                         input int unsigned head,
                                         input int unsigned n);
    return (idx - head) & (n - 1);
  endfunction

endpackage

// File: rtl/issue_pick.sv
// -----------------------------------------------------------------------------
// issue_pick
// Oldest-candidate picker: bit 0 of cand_i is the oldest slot.
// Ports:
//   cand_i   - candidate vector, age-ordered (bit i = age i)
//   onehot_o - one-hot of the lowest set candidate bit
//   idx_o    - encoded position of that bit
//   valid_o  - any candidate present
// -----------------------------------------------------------------------------
module issue_pick #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = $clog2(NCOMMIT)
) (
  input  logic [NCOMMIT-1:0]  cand_i,
  output logic [NCOMMIT-1:0]  onehot_o,
  output logic [LNCOMMIT-1:0] idx_o,
  output logic                valid_o
);

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < NCOMMIT; i++) begin
      if (cand_i[i] && !valid_o) begin
        onehot_o[i] = 1'b1;
        idx_o       = LNCOMMIT'(i);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_sched.sv
// -----------------------------------------------------------------------------
// issue_sched
// Age-ordered issue scheduler. Each cycle, units 0..NUNIT-1 in turn pick the
// oldest eligible entry of their type that no lower unit has taken, and the
// grants are registered. A pending mask blocks re-issue until the entry's
// ready bit is seen low.
//
// Build option: ISSUE_AGE_ORDER_EN
//   defined   - age is relative to commit_head (eligible vector rotated)
//   undefined - lowest index first, commit_head ignored
//
// Ports:
//   clk, reset (async, active-low)
//   commit_head  - index of the oldest live commit entry
//   entry_ready  - per-entry ready for issue
//   entry_type   - per-entry type code, LNTYPE bits each
//   unit_avail   - per-unit can accept an op next cycle
//   flush        - drops grants and clears the pending mask
//   issue_valid  - registered grant per unit
//   issue_addr   - registered commit index per unit (0 when no grant)
// -----------------------------------------------------------------------------
module issue_sched
  import issue_pkg::*;
#(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = $clog2(NCOMMIT),
  parameter int NUNIT    = 4,
  parameter int LNTYPE   = 2,
  parameter logic [NUNIT*LNTYPE-1:0] UNIT_TYPES = {TYPE_BR, TYPE_MUL, TYPE_SHIFT, TYPE_ALU}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LNCOMMIT-1:0]         commit_head,
  input  logic [NCOMMIT-1:0]          entry_ready,
  input  logic [NCOMMIT*LNTYPE-1:0]   entry_type,
  input  logic [NUNIT-1:0]            unit_avail,
  input  logic                        flush,
  output logic [NUNIT-1:0]            issue_valid,
  output logic [NUNIT*LNCOMMIT-1:0]   issue_addr
);

  logic [NCOMMIT-1:0]        pend_q, pend_d;
  logic [NCOMMIT-1:0]        elig;
  logic [NUNIT-1:0]          valid_q, valid_d;
  logic [NUNIT*LNCOMMIT-1:0] addr_q, addr_d;
  logic [NUNIT-1:0]          grant;
  logic [NUNIT*LNCOMMIT-1:0] grant_addr;

  assign elig = entry_ready & ~pend_q;

`ifndef ISSUE_AGE_ORDER_EN
  logic unused_head;
  assign unused_head = ^commit_head;
`endif

  // Priority chain: each unit sees the entries taken by the units before it.
  // An unavailable unit takes nothing, leaving its candidate to later units.
  for (genvar u = 0; u < NUNIT; u++) begin : g_unit
    logic [NCOMMIT-1:0]  taken_in, taken_out;
    logic [NCOMMIT-1:0]  cand, cand_rot, pick_oh_rot, pick_oh;
    logic [LNCOMMIT-1:0] pick_age, pick_idx;
    logic                pick_vld, gnt;

    if (u == 0) begin : g_first
      assign taken_in = '0;
    end else begin : g_chain
      assign taken_in = g_unit[u-1].taken_out;
    end

    always_comb begin
      cand = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
        cand[i] = elig[i] & ~taken_in[i] &
                  (entry_type[i*LNTYPE +: LNTYPE] == UNIT_TYPES[u*LNTYPE +: LNTYPE]);
      end
    end

`ifdef ISSUE_AGE_ORDER_EN
    // Rotate right by the head so bit 0 is the head entry; the winner is
    // rotated back the same way.
    always_comb begin
      cand_rot = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
        cand_rot[LNCOMMIT'(age_of(i, 32'(commit_head), NCOMMIT))] = cand[i];
      end
    end

    always_comb begin
      pick_oh = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
        pick_oh[i] = pick_oh_rot[LNCOMMIT'(age_of(i, 32'(commit_head), NCOMMIT))];
      end
    end

    // Wraps naturally in LNCOMMIT bits since NCOMMIT is a power of 2.
    assign pick_idx = pick_age + commit_head;
`else
    assign cand_rot = cand;
    assign pick_oh  = pick_oh_rot;
    assign pick_idx = pick_age;
`endif

    issue_pick #(
      .NCOMMIT  (NCOMMIT),
      .LNCOMMIT (LNCOMMIT)
    ) u_pick (
      .cand_i   (cand_rot),
      .onehot_o (pick_oh_rot),
      .idx_o    (pick_age),
      .valid_o  (pick_vld)
    );

    assign gnt       = pick_vld & unit_avail[u];
    assign taken_out = taken_in | (gnt ? pick_oh : '0);
    assign grant[u]  = gnt;
    assign grant_addr[u*LNCOMMIT +: LNCOMMIT] = gnt ? pick_idx : '0;
  end

  // A pending bit survives only while ready stays high; a new grant wins
  // over a same-cycle clear. Flush overrides everything.
  always_comb begin
    valid_d = grant;
    addr_d  = grant_addr;
    pend_d  = (pend_q & entry_ready) | g_unit[NUNIT-1].taken_out;
    if (flush) begin
      valid_d = '0;
      addr_d  = '0;
      pend_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      addr_q  <= '0;
      pend_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
    end
  end

  assign issue_valid = valid_q;
  assign issue_addr  = addr_q;

endmodule

// File: tb/tb_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_issue_sched
// Self-checking bench for issue_sched: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (age-ordered walk over the ring, per-unit in order).
// -----------------------------------------------------------------------------
module tb_issue_sched;
  import issue_pkg::*;

  localparam int N  = 32;
  localparam int LN = 5;
  localparam int NU = 4;
  localparam int LT = 2;
  // Units 0 and 1 share the ALU type to exercise the k-th oldest rule.
  localparam logic [NU*LT-1:0] UT = {TYPE_MUL, TYPE_SHIFT, TYPE_ALU, TYPE_ALU};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [LN-1:0]     commit_head = '0;
  logic [N-1:0]      entry_ready = '1;
  logic [N*LT-1:0]   entry_type = '0;
  logic [NU-1:0]     unit_avail = '1;
  logic              flush = 1'b0;
  logic [NU-1:0]     issue_valid;
  logic [NU*LN-1:0]  issue_addr;

  int vectors = 0;
  int miscompares = 0;

  issue_sched #(
    .NCOMMIT    (N),
    .LNCOMMIT   (LN),
    .NUNIT      (NU),
    .LNTYPE     (LT),
    .UNIT_TYPES (UT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .commit_head (commit_head),
    .entry_ready (entry_ready),
    .entry_type  (entry_type),
    .unit_avail  (unit_avail),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]  pend_m = '0;
  logic [NU-1:0] exp_valid = '0;
  logic [LN-1:0] exp_addr [NU];
  logic [N-1:0]  m_taken;
  logic [NU-1:0] m_nv;
  logic [LN-1:0] m_na [NU];
  int            m_idx;

  initial for (int u = 0; u < NU; u++) exp_addr[u] = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_m    <= '0;
      exp_valid <= '0;
      for (int u = 0; u < NU; u++) exp_addr[u] <= '0;
    end else if (flush) begin
      pend_m    <= '0;
      exp_valid <= '0;
      for (int u = 0; u < NU; u++) exp_addr[u] <= '0;
    end else begin
      m_taken = '0;
      for (int u = 0; u < NU; u++) begin
        m_nv[u] = 1'b0;
        m_na[u] = '0;
        if (unit_avail[u]) begin
          // Walk the entries from oldest to youngest; first match wins.
          for (int a = 0; a < N; a++) begin
`ifdef ISSUE_AGE_ORDER_EN
            m_idx = (int'(commit_head) + a) % N;
`else
            m_idx = a;
`endif
            if (!m_nv[u] && entry_ready[m_idx] && !pend_m[m_idx] && !m_taken[m_idx] &&
                entry_type[m_idx*LT +: LT] == UT[u*LT +: LT]) begin
              m_nv[u] = 1'b1;
              m_na[u] = LN'(m_idx);
              m_taken[m_idx] = 1'b1;
            end
          end
        end
      end
      pend_m    <= (pend_m & entry_ready) | m_taken;
      exp_valid <= m_nv;
      for (int u = 0; u < NU; u++) exp_addr[u] <= m_na[u];
    end
  end

  // Compare process: one step after every rising edge.
  always @(posedge clk) begin
    #1;
    check("cyc_valid", 32'(issue_valid), 32'(exp_valid));
    for (int u = 0; u < NU; u++) begin
      if (exp_valid[u])
        check($sformatf("cyc_u%0d_addr", u), 32'(issue_addr[u*LN +: LN]), 32'(exp_addr[u]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    entry_ready = '0;
    flush       = 1'b0;
    unit_avail  = '1;
    commit_head = '0;
    entry_type  = '0;
    cyc();
    cyc();
  endtask

  int wrap_order [3];

  initial begin
    // Reset held with every entry ready.
    repeat (3) begin
      cyc();
      check("rst_valid", 32'(issue_valid), 32'h0);
      check("rst_addr", 32'(issue_addr), 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();
    check("rel_edge_valid", 32'(issue_valid), 32'h0);
    cyc();
    check("first_valid", 32'(issue_valid), 32'h3);
    check("first_addr0", 32'(issue_addr[LN-1:0]), 32'd0);
    check("first_addr1", 32'(issue_addr[2*LN-1:LN]), 32'd1);
    idle();

    // Wrap age order, single ALU unit available.
`ifdef ISSUE_AGE_ORDER_EN
    wrap_order = '{31, 2, 29};
`else
    wrap_order = '{2, 29, 31};
`endif
    commit_head = 5'd30;
    unit_avail  = 4'b0001;
    entry_ready = '0;
    entry_ready[31] = 1'b1;
    entry_ready[2]  = 1'b1;
    entry_ready[29] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("wrap%0d_valid", k), 32'(issue_valid), 32'h1);
      check($sformatf("wrap%0d_addr", k), 32'(issue_addr[LN-1:0]), 32'(wrap_order[k]));
      entry_ready[wrap_order[k]] = 1'b0;
    end
    idle();

    // Shared type: two ALU units in one cycle, leftover next cycle.
    entry_ready[5] = 1'b1;
    entry_ready[3] = 1'b1;
    entry_ready[9] = 1'b1;
    cyc();
    check("shared_valid0", 32'(issue_valid), 32'h3);
    check("shared_u0", 32'(issue_addr[LN-1:0]), 32'd3);
    check("shared_u1", 32'(issue_addr[2*LN-1:LN]), 32'd5);
    cyc();
    check("shared_valid1", 32'(issue_valid), 32'h1);
    check("shared_u0_next", 32'(issue_addr[LN-1:0]), 32'd9);
    idle();

    // Busy unit: no ALU unit available, then unit 0 returns.
    entry_ready[4] = 1'b1;
    unit_avail = 4'b1100;
    cyc();
    check("busy_valid0", 32'(issue_valid), 32'h0);
    cyc();
    check("busy_valid1", 32'(issue_valid), 32'h0);
    unit_avail = 4'b1101;
    cyc();
    check("busy_valid2", 32'(issue_valid), 32'h1);
    check("busy_addr", 32'(issue_addr[LN-1:0]), 32'd4);
    idle();

    // Busy unit 0 passes its candidate to unit 1.
    entry_ready[4] = 1'b1;
    unit_avail = 4'b1110;
    cyc();
    check("pass_valid", 32'(issue_valid), 32'h2);
    check("pass_addr", 32'(issue_addr[2*LN-1:LN]), 32'd4);
    idle();

    // No double issue while ready stays high.
    entry_ready[7] = 1'b1;
    cyc();
    check("once_valid", 32'(issue_valid), 32'h1);
    check("once_addr", 32'(issue_addr[LN-1:0]), 32'd7);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("hold%0d_valid", k), 32'(issue_valid), 32'h0);
    end
    entry_ready[7] = 1'b0;
    cyc();
    check("drop_valid", 32'(issue_valid), 32'h0);
    entry_ready[7] = 1'b1;
    cyc();
    check("reissue_valid", 32'(issue_valid), 32'h1);
    check("reissue_addr", 32'(issue_addr[LN-1:0]), 32'd7);
    idle();

    // Flush race.
    entry_ready[6] = 1'b1;
    flush = 1'b1;
    cyc();
    check("flush_valid", 32'(issue_valid), 32'h0);
    flush = 1'b0;
    cyc();
    check("post_flush_valid", 32'(issue_valid), 32'h1);
    check("post_flush_addr", 32'(issue_addr[LN-1:0]), 32'd6);
    idle();

    // Randomized traffic; entries tend to stay ready to exercise the pending mask.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        entry_ready = N'($urandom());
      else
        entry_ready = (entry_ready & N'($urandom() | $urandom())) |
                      N'($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 7) == 0)
        entry_type = {$urandom(), $urandom()};
      commit_head = LN'($urandom_range(0, N - 1));
      unit_avail  = NU'($urandom_range(0, 15));
      flush       = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 199) != 0);
      cyc();
    end
    reset = 1'b1;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
